lcd_pix_packer: RTL

- Sits directly downstream of the LCD drive interface's brightness-adjustment output.
- Consumes one two-pixel RGB888 beat per cycle, with no backpressure on the input side.
- Packs the byte stream into 32-bit little-endian words and buffers them in a small FIFO.
- Presents the words on a valid/ready stream with an end-of-frame marker, for a frame writer or AHB master.

---
 rtl/lcd_pix_packer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lcd_pix_packer.sv
// Packs two-pixel RGB888 beats into 32-bit little-endian words, buffered in a FIFO
// and presented on a valid/ready stream. Optional macro LCD_PACK_SWAP_RB_EN selects BGR order.
module lcd_pix_packer #(
    parameter int unsigned IMG_PIX_W       = 8,
    parameter int unsigned W_DATA          = 32,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned W_FIFO_ADDR     = 4,
    parameter int unsigned WIDTH           = 768,
    parameter int unsigned HEIGHT          = 512,
    parameter int unsigned PAIRS_PER_FRAME = WIDTH * HEIGHT / 2
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   in_valid,
    input  logic [IMG_PIX_W-1:0]   in_r0,
    input  logic [IMG_PIX_W-1:0]   in_g0,
    input  logic [IMG_PIX_W-1:0]   in_b0,
    input  logic [IMG_PIX_W-1:0]   in_r1,
    input  logic [IMG_PIX_W-1:0]   in_g1,
    input  logic [IMG_PIX_W-1:0]   in_b1,
    output logic                   out_valid,
    output logic [W_DATA-1:0]      out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   frame_done,
    output logic                   stat_overflow,
    output logic [W_FIFO_ADDR:0]   stat_level
);

    localparam int unsigned W_LVL = W_FIFO_ADDR + 1;
    localparam int unsigned W_CNT = (PAIRS_PER_FRAME > 1) ? $clog2(PAIRS_PER_FRAME) : 1;
    localparam logic [W_LVL-1:0] DEPTH_L   = W_LVL'(FIFO_DEPTH);
    localparam logic [W_CNT-1:0] LAST_PAIR = W_CNT'(PAIRS_PER_FRAME - 1);

    typedef enum logic {StBeatA, StBeatB} phase_e;

    phase_e                    phase_q, phase_d;
    logic [2*IMG_PIX_W-1:0]    residue_q, residue_d;
    logic [W_CNT-1:0]          pair_cnt_q, pair_cnt_d;
    logic [W_LVL-1:0]          count_q, count_d;
    logic [W_FIFO_ADDR-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_inc;
    logic                      overflow_q, overflow_d;
    logic                      frame_done_q, frame_done_d;
    logic [W_DATA:0]           mem [FIFO_DEPTH];

    logic [IMG_PIX_W-1:0]      a0, a1, a2, a3, a4, a5;
    logic [W_DATA:0]           wr0, wr1, head;
    logic [1:0]                push_n;
    logic                      fits, accept, pop, frame_end;

    // a0..a5 is the byte stream order of one beat
`ifdef LCD_PACK_SWAP_RB_EN
    assign {a0, a1, a2} = {in_b0, in_g0, in_r0};
    assign {a3, a4, a5} = {in_b1, in_g1, in_r1};
`else
    assign {a0, a1, a2} = {in_r0, in_g0, in_b0};
    assign {a3, a4, a5} = {in_r1, in_g1, in_b1};
`endif

    assign head       = mem[rd_ptr_q];
    assign wr_ptr_inc = wr_ptr_q + 1'b1;

    always_comb begin
        phase_d      = phase_q;
        residue_d    = residue_q;
        pair_cnt_d   = pair_cnt_q;
        overflow_d   = overflow_q;
        push_n       = 2'd0;
        wr0          = '0;
        wr1          = '0;
        frame_end    = (pair_cnt_q == LAST_PAIR);
        pop          = (count_q != '0) && out_ready;
        // Room is judged on the occupancy before this cycle's pop
        fits         = (phase_q == StBeatA) ? (count_q != DEPTH_L)
                                            : (count_q <= DEPTH_L - W_LVL'(2));
        accept       = in_valid && fits;

        if (accept) begin
            if (phase_q == StBeatA) begin
                push_n    = 2'd1;
                wr0       = {1'b0, a3, a2, a1, a0};
                residue_d = {a5, a4};
                phase_d   = StBeatB;
            end else begin
                push_n  = 2'd2;
                wr0     = {1'b0, a1, a0, residue_q};
                wr1     = {frame_end, a5, a4, a3, a2};
                phase_d = StBeatA;
            end
        end

        if (in_valid) begin
            if (!fits) overflow_d = 1'b1;
            if (frame_end) begin
                pair_cnt_d = '0;
                phase_d    = StBeatA;
            end else begin
                pair_cnt_d = pair_cnt_q + 1'b1;
            end
        end

        count_d      = count_q + W_LVL'(push_n) - W_LVL'(pop);
        wr_ptr_d     = wr_ptr_q + W_FIFO_ADDR'(push_n);
        rd_ptr_d     = rd_ptr_q + W_FIFO_ADDR'(pop);
        frame_done_d = pop && head[W_DATA];
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            phase_q      <= StBeatA;
            residue_q    <= '0;
            pair_cnt_q   <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            residue_q    <= residue_d;
            pair_cnt_q   <= pair_cnt_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage needs no reset: the read side is masked while empty
    always_ff @(posedge HCLK) begin
        if (push_n != 2'd0) mem[wr_ptr_q]   <= wr0;
        if (push_n == 2'd2) mem[wr_ptr_inc] <= wr1;
    end

    assign out_valid     = (count_q != '0);
    assign out_data      = out_valid ? head[W_DATA-1:0] : '0;
    assign out_last      = out_valid & head[W_DATA];
    assign frame_done    = frame_done_q;
    assign stat_overflow = overflow_q;
    assign stat_level    = count_q;

endmodule
